// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg : shared I2S word width and receive FSM state encoding
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package i2s_pkg;

    localparam int I2S_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } i2si_state_t;

endpackage

`default_nettype wire

// File: rtl/i2si_deserializer_if.sv
// -----------------------------------------------------------------------------
// i2si_deserializer_if : stereo pair handshake bus (optional I2SI_OVERRUN_EN)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface i2si_deserializer_if
    import i2s_pkg::*;
#(
    parameter int WORD_W = I2S_WORD_W
);

    logic [WORD_W-1:0] i2si_lft;
    logic [WORD_W-1:0] i2si_rgt;
    logic              i2si_rts;
    logic              i2si_ack;

`ifdef I2SI_OVERRUN_EN
    logic              i2si_overrun;

    modport master (output i2si_lft, i2si_rgt, i2si_rts, i2si_overrun, input i2si_ack);
    modport slave  (input  i2si_lft, i2si_rgt, i2si_rts, i2si_overrun, output i2si_ack);
`else
    modport master (output i2si_lft, i2si_rgt, i2si_rts, input i2si_ack);
    modport slave  (input  i2si_lft, i2si_rgt, i2si_rts, output i2si_ack);
`endif

endinterface

`default_nettype wire

// File: rtl/i2si_deserializer_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff : N-stage single-bit synchroniser, async active-low reset to 0
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/i2si_deserializer.sv
// -----------------------------------------------------------------------------
// i2si_deserializer : I2S receiver, SCK strobe + 16-bit stereo pair capture
// Optional sticky overrun flag with I2SI_OVERRUN_EN.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module i2si_deserializer
    import i2s_pkg::*;
#(
    parameter int WORD_W      = I2S_WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i2si_en,
    input  logic                i2si_sck,
    input  logic                i2si_ws,
    input  logic                i2si_sd,
    output logic                i2si_sck_transition,
    i2si_deserializer_if.master bus
);

    localparam int              CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WORD_W);

    logic sck_s, ws_s, sd_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .rst_n(rst_n), .d_i(i2si_sck), .q_o(sck_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ws  (.clk(clk), .rst_n(rst_n), .d_i(i2si_ws),  .q_o(ws_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd  (.clk(clk), .rst_n(rst_n), .d_i(i2si_sd),  .q_o(sd_s));

    // WS/SD get the same extra flop as SCK so the sampled bit lines up with the rise.
    logic sck_d_q, ws_d_q, sd_d_q, trans_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_d_q <= 1'b0;
            ws_d_q  <= 1'b0;
            sd_d_q  <= 1'b0;
            trans_q <= 1'b0;
        end else begin
            sck_d_q <= sck_s;
            ws_d_q  <= ws_s;
            sd_d_q  <= sd_s;
            trans_q <= sck_s & ~sck_d_q;
        end
    end

    assign i2si_sck_transition = trans_q;

    i2si_state_t       state_q, state_d;
    logic [CNT_W-1:0]  bits_q, bits_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0] lft_q, lft_d;
    logic [WORD_W-1:0] rgt_q, rgt_d;
    logic              ws_prev_q, ws_prev_d;
    logic              rts_q, rts_d;

    logic              w_boundary;
    logic              w_publish;
    logic [CNT_W-1:0]  w_bits_in;
    logic [WORD_W-1:0] w_shreg_in;
    logic [WORD_W-1:0] w_justified;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bits_q    <= '0;
            shreg_q   <= '0;
            hold_q    <= '0;
            lft_q     <= '0;
            rgt_q     <= '0;
            ws_prev_q <= 1'b0;
            rts_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            lft_q     <= lft_d;
            rgt_q     <= rgt_d;
            ws_prev_q <= ws_prev_d;
            rts_q     <= rts_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        shreg_d    = shreg_q;
        hold_d     = hold_q;
        lft_d      = lft_q;
        rgt_d      = rgt_q;
        ws_prev_d  = ws_prev_q;
        rts_d      = rts_q;
        w_publish  = 1'b0;
        w_boundary = trans_q && (ws_d_q != ws_prev_q);

        // Bits past WORD_W are dropped, so long words keep their leading bits.
        if (bits_q < FULL) begin
            w_shreg_in = {shreg_q[WORD_W-2:0], sd_d_q};
            w_bits_in  = bits_q + CNT_W'(1);
        end else begin
            w_shreg_in = shreg_q;
            w_bits_in  = bits_q;
        end
        w_justified = w_shreg_in << (FULL - w_bits_in);

        if (trans_q) begin
            ws_prev_d = ws_d_q;
        end

        if (!i2si_en) begin
            state_d = IDLE;
            bits_d  = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    bits_d  = '0;
                    shreg_d = '0;
                    state_d = ALIGN;
                end
                ALIGN: begin
                    bits_d  = '0;
                    shreg_d = '0;
                    if (w_boundary && !ws_d_q) begin
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (w_boundary) begin
                        hold_d  = w_justified;
                        bits_d  = '0;
                        shreg_d = '0;
                        state_d = RIGHT;
                    end else if (trans_q) begin
                        bits_d  = w_bits_in;
                        shreg_d = w_shreg_in;
                    end
                end
                RIGHT: begin
                    if (w_boundary) begin
                        lft_d     = hold_q;
                        rgt_d     = w_justified;
                        w_publish = 1'b1;
                        bits_d    = '0;
                        shreg_d   = '0;
                        state_d   = LEFT;
                    end else if (trans_q) begin
                        bits_d  = w_bits_in;
                        shreg_d = w_shreg_in;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A fresh pair wins over a same-cycle acknowledge of the old one.
        if (rts_q && bus.i2si_ack) begin
            rts_d = 1'b0;
        end
        if (w_publish) begin
            rts_d = 1'b1;
        end
    end

    assign bus.i2si_lft = lft_q;
    assign bus.i2si_rgt = rgt_q;
    assign bus.i2si_rts = rts_q;

`ifdef I2SI_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (w_publish && rts_q && !bus.i2si_ack) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.i2si_overrun = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2si_deserializer.sv
// -----------------------------------------------------------------------------
// tb_i2si_deserializer : randomized I2S transmitter vs. word-level pair model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_i2si_deserializer;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic sck;
    logic ws;
    logic sd;
    logic trans;

    i2si_deserializer_if bus_if ();

    i2si_deserializer #(
        .WORD_W      (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i2si_en             (en),
        .i2si_sck            (sck),
        .i2si_ws             (ws),
        .i2si_sd             (sd),
        .i2si_sck_transition (trans),
        .bus                 (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int pulse_total = 0;
    always @(negedge clk) begin
        if (trans === 1'b1) pulse_total++;
    end

    // Word-level model of what the receiver should be presenting.
    logic [15:0] exp_l   = '0;
    logic [15:0] exp_r   = '0;
    bit          exp_rts = 1'b0;
    bit          exp_ovr = 1'b0;

    bit          trans_chk = 1'b0;
    logic [15:0] lat_l, lat_r;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] justify(input logic [31:0] w, input int n);
        logic [31:0] t;
        if (n >= 16) t = w >> (n - 16);
        else         t = w << (16 - n);
        return t[15:0];
    endfunction

    task automatic check_out();
        check_val("lft", bus_if.i2si_lft, exp_l);
        check_val("rgt", bus_if.i2si_rgt, exp_r);
        check_val("rts", bus_if.i2si_rts, exp_rts);
`ifdef I2SI_OVERRUN_EN
        check_val("overrun", bus_if.i2si_overrun, exp_ovr);
`endif
    endtask

    // One SCK period of 8 clk: WS/SD change with the falling edge.
    task automatic shift_bit(input logic w, input logic d, input bit lat);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        sck = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (trans_chk) begin
                if (i == 3) check_val("sck_pulse", trans, 1);
                else        check_val("sck_nopulse", trans, 0);
            end
            if (lat) begin
                if (i == 3) check_val("pub_early_rts", bus_if.i2si_rts, 0);
                if (i == 4) begin
                    check_val("pub_lat_rts", bus_if.i2si_rts, 1);
                    check_val("pub_lat_lft", bus_if.i2si_lft, lat_l);
                    check_val("pub_lat_rgt", bus_if.i2si_rgt, lat_r);
                end
            end
        end
    endtask

    // WS flips together with the LSB: I2S one-bit delay.
    task automatic send_word(input bit ch, input logic [31:0] w, input int n, input bit lat);
        for (int i = 0; i < n; i++) begin
            shift_bit((i == n - 1) ? ~ch : ch, w[n-1-i], lat && (i == n - 1));
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input int ln, input logic [31:0] r, input int rn,
                              input bit lat, input bit pub);
        if (lat) begin
            lat_l = justify(l, ln);
            lat_r = justify(r, rn);
        end
        send_word(1'b0, l, ln, 1'b0);
        send_word(1'b1, r, rn, lat);
        if (pub) begin
            if (exp_rts) exp_ovr = 1'b1;
            exp_l   = justify(l, ln);
            exp_r   = justify(r, rn);
            exp_rts = 1'b1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack();
        bus_if.i2si_ack = 1'b1;
        @(posedge clk);
        #1;
        bus_if.i2si_ack = 1'b0;
        exp_rts = 1'b0;
        check_val("rts_after_ack", bus_if.i2si_rts, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          p0;
        int          ln, rn;
        logic [31:0] lw, rw;

        rst_n = 1'b0;
        en    = 1'b0;
        sck   = 1'b0;
        ws    = 1'b0;
        sd    = 1'b0;
        bus_if.i2si_ack = 1'b0;

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_out();
        check_val("trans_reset", trans, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Strobe runs with the receiver disabled.
        p0 = pulse_total;
        trans_chk = 1'b1;
        repeat (6) shift_bit(1'b0, 1'b0, 1'b0);
        trans_chk = 1'b0;
        check_val("pulse_count", pulse_total - p0, 6);

        en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_frame($urandom & 32'hFFFF, 16, $urandom & 32'hFFFF, 16, 1'b0, 1'b0);
        check_out();
        send_frame(32'hA5C3, 16, 32'h0F0F, 16, 1'b1, 1'b1);
        check_out();

        // Overwrite without acknowledge.
        send_frame(32'h1234, 16, 32'h5678, 16, 1'b0, 1'b1);
        check_out();
        do_ack();

        send_frame(32'hABC, 12, 32'h123, 12, 1'b0, 1'b1);
        check_out();
        do_ack();

        send_frame(32'hFEDCB, 20, 32'h8001, 16, 1'b0, 1'b1);
        check_out();

        // Disable partway through a left word.
        lw = 32'h3C5A;
        for (int i = 0; i < 7; i++) shift_bit(1'b0, lw[15-i], 1'b0);
        en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_out();
        do_ack();
        en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_frame($urandom & 32'hFFFF, 16, $urandom & 32'hFFFF, 16, 1'b0, 1'b0);
        check_out();
        send_frame(32'h7E81, 16, 32'hC3C3, 16, 1'b0, 1'b1);
        check_out();

        // Reset in the middle of a word with a pair still pending.
        for (int i = 0; i < 10; i++) shift_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        rst_n = 1'b0;
        #1;
        exp_l   = '0;
        exp_r   = '0;
        exp_rts = 1'b0;
        exp_ovr = 1'b0;
        check_out();
        check_val("trans_in_reset", trans, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check_val("rts_after_reset", bus_if.i2si_rts, 0);

        send_frame($urandom & 32'hFFFF, 16, $urandom & 32'hFFFF, 16, 1'b0, 1'b0);
        check_out();
        for (int f = 0; f < 10; f++) begin
            ln = $urandom_range(8, 24);
            rn = $urandom_range(8, 24);
            lw = $urandom & ((32'd1 << ln) - 32'd1);
            rw = $urandom & ((32'd1 << rn) - 32'd1);
            send_frame(lw, ln, rw, rn, 1'b0, 1'b1);
            check_out();
            if ($urandom_range(0, 1) == 1) do_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2si_deserializer.md
# i2si_deserializer

I2S receive front end: synchronises the external I2S bit clock, word select and serial data into the `clk` domain and produces a one-cycle `i2si_sck_transition` pulse per SCK rising edge. The `i2so` serializer uses that pulse as its bit strobe. The block also deserialises incoming left/right samples into 16-bit parallel words and hands each completed stereo pair to the downstream audio path with a ready-to-send / acknowledge handshake.

## Interface
- WORD_W, 16, bits per channel word delivered on the parallel outputs
- SYNC_STAGES, 2, flip-flops per input synchroniser; legal values are 2 or 3
- clk  input  1  master clock
- rst_n  input  1  asynchronous, active-low reset
- i2si_en  input  1  receive enable; level-sensitive
- i2si_sck  input  1  external I2S bit clock, asynchronous to `clk`
- i2si_ws  input  1  external word select: 0 = left, 1 = right
- i2si_sd  input  1  external serial data, MSB first
- i2si_ack  input  1  downstream has taken the current pair
- i2si_sck_transition  output  1  one-clk pulse per synchronised SCK rising edge
- i2si_lft  output  WORD_W  last completed left word
- i2si_rgt  output  WORD_W  last completed right word
- i2si_rts  output  1  stereo pair valid; held high until acknowledged
- i2si_overrun  output  1  sticky overrun flag; present only when `I2SI_OVERRUN_EN` is defined

## Operation
- `sck`, `ws` and `sd` each pass through a SYNC_STAGES synchroniser.
- A further flop on the synchronised SCK gives edge detection: `i2si_sck_transition = sck_s & ~sck_d`.
- `ws` and `sd` are sampled only on the transition pulse. Their pipeline depth equals SCK's, so SD is sampled on the SCK rising edge.
- `ws_prev` holds the WS value from the previous SCK rise. A rise where the sampled WS differs from `ws_prev` is a boundary rise; the SD bit taken on that rise is the LSB of the word being closed, per I2S one-bit delay.
- FSM states: IDLE, ALIGN, LEFT, RIGHT.
  - IDLE: `i2si_en` = 0. Shift register and bit counter are cleared. Moves to ALIGN on the clk after `i2si_en` = 1.
  - ALIGN: waits for a boundary rise with WS going 1->0. The bit on that rise is discarded; moves to LEFT. This ensures the first pair published is complete.
  - LEFT: on each non-boundary rise, shift SD in while the bit counter is below WORD_W. Further bits are discarded and the counter saturates at WORD_W.
    - On a boundary rise (WS = 1): include the current bit under the same rule, then left-justify and store in a holding register; move to RIGHT.
  - RIGHT: same shifting rules. On a boundary rise (WS = 0): include the bit, left-justify, then load `i2si_lft` from the holding register and `i2si_rgt` together in the same clk. Set `i2si_rts`; move to LEFT.
- Left-justify rule: a word with N < WORD_W bits is zero-filled in its LSBs. A word with N > WORD_W bits keeps its first WORD_W bits.
- Handshake: `i2si_rts` falls on the clk after a cycle with `i2si_rts` & `i2si_ack` both high. `i2si_ack` while `i2si_rts` = 0 is ignored.
- Simultaneous publish and ack: the ack retires the old pair, the new pair is loaded, and `i2si_rts` stays 1.
- Publish while `i2si_rts` = 1 without ack: the new pair overwrites the old one and `i2si_rts` stays 1 (see Configuration).
- `i2si_en` falling mid-frame: FSM goes to IDLE on the next clk and the partial word is discarded. `i2si_lft`, `i2si_rgt` and `i2si_rts` hold their values, and the handshake still completes normally.
- The synchronisers and `i2si_sck_transition` run regardless of `i2si_en`.

## Timing
- Reset values: `i2si_sck_transition` 0, `i2si_lft` 0, `i2si_rgt` 0, `i2si_rts` 0, `i2si_overrun` 0, FSM IDLE, `ws_prev` 0.
- Pin SCK rise to `i2si_sck_transition` high: SYNC_STAGES+1 clk edges. The pulse is exactly 1 clk wide.
- Final right LSB rise on the pin to `i2si_lft`/`i2si_rgt`/`i2si_rts` update: SYNC_STAGES+2 clk edges.
- Requirement: SCK high and low phases each at least 2 clk periods, so f_clk ≥ 4·f_sck. Behaviour outside this limit is undefined.

## Configuration
- `I2SI_OVERRUN_EN` defined:
  - `i2si_overrun` port and flop exist.
  - The flag sets when a pair is published while `i2si_rts` = 1 and `i2si_ack` = 0.
  - It is cleared only by `rst_n`.
- Not defined: the port is absent and overwrites are silent.

## Structure
- Shared package `i2s_pkg`:
  - `I2S_WORD_W` = 16, used as the WORD_W default.
  - State enum `i2si_state_t` {IDLE, ALIGN, LEFT, RIGHT}.
- Sub-module `sync_ff`: parameterised N-stage synchroniser with async active-low reset to 0, instantiated three times.

## Test plan
- Reset asserted mid-stream -> all outputs 0, FSM IDLE. After release with no SCK activity, `i2si_rts` stays 0.
- SCK at f_clk/8 toggling -> `i2si_sck_transition` pulses exactly once per SCK period, 1 clk wide, 3 clk after each pin rise (SYNC_STAGES = 2).
- En, one 16-bit I2S frame with L = 0xA5C3 and R = 0x0F0F after an alignment frame -> `i2si_lft` = 0xA5C3, `i2si_rgt` = 0x0F0F, `i2si_rts` = 1, updated in the same clk.
- Hold `i2si_ack` = 0 across two frames, second frame L = 0x1234 -> outputs show 0x1234 and `i2si_rts` stays 1. With the macro, `i2si_overrun` = 1. Then `i2si_ack` = 1 for 1 clk -> `i2si_rts` = 0 on the next clk.
- 12-bit words L = 0xABC, R = 0x123 -> `i2si_lft` = 0xABC0, `i2si_rgt` = 0x1230. 20-bit word 0xFEDCB -> 0xFEDC.
- Drop `i2si_en` at left bit 7 -> previous pair held. Re-enable -> first new pair published only after ALIGN sees WS go 1->0.
